restoring_div_controller: RTL and testbench

FSM sequencer for the restoring-division datapath (WIDTH-bit quotient/remainder registers plus subtractor). It accepts Start from the input wrapper once operands are assembled, then drives load, shift, subtract and restore/quotient-set strobes for WIDTH iterations. It holds Done until the output side acknowledges. It owns no data: the datapath reports only the sign of the trial remainder and the divisor-zero flag.

---
 rtl/restoring_div_controller_pkg.sv | 19 +
 rtl/restoring_div_controller_if.sv | 41 ++++
 rtl/restoring_div_controller_iter_counter.sv | 36 +++
 rtl/restoring_div_controller.sv | 112 +++++++++++
 tb/tb_restoring_div_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/restoring_div_controller_pkg.sv
// Shared types and constants for the restoring-division controller.
// The optional status outputs are enabled with `define DIV_STATUS_EN.
package div_pkg;

    localparam int unsigned DefWidth = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StSub,
        StCheck,
        StDone
    } div_state_t;

    // Edges from the Start sample to Done for a non-error operation.
    localparam int unsigned OpCycles = 3 * DefWidth + 1;

endpackage

// File: rtl/restoring_div_controller_if.sv
// Handshake and strobe bundle between the division controller and its datapath/wrappers.
// Busy and OpCount exist only when DIV_STATUS_EN is defined.
interface restoring_div_controller_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
);
    logic             Start;
    logic             Neg;
    logic             DivisorZero;
    logic             OutputAccepted;
    logic             ReadyForInput;
    logic             LdOperands;
    logic             ShiftQR;
    logic             Sub;
    logic             Restore;
    logic             SetQ0;
    logic             Done;
    logic             Error;
    logic [CNT_W-1:0] Count;
`ifdef DIV_STATUS_EN
    logic             Busy;
    logic [15:0]      OpCount;
`endif

    modport master (
        input  Start, Neg, DivisorZero, OutputAccepted,
        output ReadyForInput, LdOperands, ShiftQR, Sub, Restore, SetQ0, Done, Error, Count
`ifdef DIV_STATUS_EN
        , output Busy, OpCount
`endif
    );

    modport slave (
        output Start, Neg, DivisorZero, OutputAccepted,
        input  ReadyForInput, LdOperands, ShiftQR, Sub, Restore, SetQ0, Done, Error, Count
`ifdef DIV_STATUS_EN
        , input Busy, OpCount
`endif
    );

endinterface

// File: rtl/restoring_div_controller_iter_counter.sv
// Iteration counter for the division sequencer: clear has priority over increment,
// last_o flags the final iteration (WIDTH-1).
module div_iter_counter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign last_o  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/restoring_div_controller.sv
// FSM sequencer for a restoring-division datapath: load, then WIDTH shift/sub/check rounds.
// Defining DIV_STATUS_EN adds Busy and a saturating completed-operation counter OpCount.
module restoring_div_controller
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input logic                         clk,
    input logic                         reset,
    restoring_div_controller_if.master  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic             error_q, error_d;
    logic             cnt_clr, cnt_inc, cnt_last;
    logic [CNT_W-1:0] count;

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (count),
        .last_o  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            StIdle: if (bus.Start) state_d = StLoad;
            StLoad: begin
                cnt_clr = 1'b1;
                if (bus.DivisorZero) begin
                    state_d = StDone;
                    error_d = 1'b1;
                end else begin
                    state_d = StShift;
                    error_d = 1'b0;
                end
            end
            StShift: state_d = StSub;
            StSub:   state_d = StCheck;
            StCheck: begin
                if (cnt_last) begin
                    state_d = StDone;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = StShift;
                end
            end
            StDone: begin
                if (bus.OutputAccepted) begin
                    state_d = StIdle;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
        end
    end

    // Restore/SetQ0 are the only outputs that look at a live input (Neg).
    assign bus.ReadyForInput = (state_q == StIdle);
    assign bus.LdOperands    = (state_q == StLoad);
    assign bus.ShiftQR       = (state_q == StShift);
    assign bus.Sub           = (state_q == StSub);
    assign bus.Restore       = (state_q == StCheck) && bus.Neg;
    assign bus.SetQ0         = (state_q == StCheck) && !bus.Neg;
    assign bus.Done          = (state_q == StDone);
    assign bus.Error         = (state_q == StDone) && error_q;
    assign bus.Count         = count;

`ifdef DIV_STATUS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == StDone && bus.OutputAccepted && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign bus.Busy    = (state_q == StLoad) || (state_q == StShift) ||
                         (state_q == StSub)  || (state_q == StCheck);
    assign bus.OpCount = op_count_q;
`endif

endmodule

// File: tb/tb_restoring_div_controller.sv
// Directed self-checking bench for restoring_div_controller (WIDTH=16).
// Also exercises Busy/OpCount when built with DIV_STATUS_EN.
module tb_restoring_div_controller;
    import div_pkg::*;

    localparam int unsigned W = DefWidth;

    logic clk;
    logic reset;

    restoring_div_controller_if #(.WIDTH(W)) bus ();

    restoring_div_controller #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neg stimulus: 0 = always 0, 1 = high on even iterations.
    int neg_mode = 0;
    assign bus.Neg = (neg_mode == 1) ? ~bus.Count[0] : 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Strobe tallies, cleared at any falling edge where cnt_en is low.
    bit          cnt_en = 1'b0;
    int          n_ld, n_shift, n_sub, n_rest, n_setq, n_busy;
    logic [15:0] rest_mask, setq_mask;

    always @(negedge clk) begin
        if (!cnt_en) begin
            n_ld = 0; n_shift = 0; n_sub = 0; n_rest = 0; n_setq = 0; n_busy = 0;
            rest_mask = '0; setq_mask = '0;
        end else begin
            if (bus.LdOperands) n_ld++;
            if (bus.ShiftQR) n_shift++;
            if (bus.Sub) n_sub++;
            if (bus.Restore) begin n_rest++; rest_mask[bus.Count] = 1'b1; end
            if (bus.SetQ0) begin n_setq++; setq_mask[bus.Count] = 1'b1; end
`ifdef DIV_STATUS_EN
            if (bus.Busy) n_busy++;
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_count();
        cnt_en = 1'b0;
        step();
        cnt_en = 1'b1;
    endtask

    task automatic start_op(input bit dz);
        bus.Start       = 1'b1;
        bus.DivisorZero = dz;
        step();
        bus.Start = 1'b0;
    endtask

    // n = number of edges after the Start-sampling edge until Done is seen.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.Done && n < 200) begin
            step();
            n++;
        end
        if (!bus.Done) check("done_timeout", 32'(bus.Done), 32'd1);
    endtask

    task automatic accept(input string tag);
        bus.OutputAccepted = 1'b1;
        step();
        bus.OutputAccepted = 1'b0;
        check({tag, "_ready"}, 32'(bus.ReadyForInput), 32'd1);
        check({tag, "_done_low"}, 32'(bus.Done), 32'd0);
        check({tag, "_count0"}, 32'(bus.Count), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(bus.ReadyForInput), 32'd1);
        check({tag, "_count"}, 32'(bus.Count), 32'd0);
        check({tag, "_strobes"},
              32'({bus.LdOperands, bus.ShiftQR, bus.Sub, bus.Restore, bus.SetQ0,
                   bus.Done, bus.Error}), 32'd0);
    endtask

    initial begin
        int n;
        int guard;
        reset              = 1'b0;
        bus.Start          = 1'b0;
        bus.DivisorZero    = 1'b0;
        bus.OutputAccepted = 1'b0;

        step();
        step();
        check_idle("reset");
        reset = 1'b1;

        // All-SetQ0 run.
        neg_mode = 0;
        restart_count();
        start_op(1'b0);
        check("load_state", 32'(bus.LdOperands), 32'd1);
        wait_done(n);
        check("negzero_latency", 32'(n), 32'(OpCycles));
        check("negzero_error", 32'(bus.Error), 32'd0);
        check("negzero_ld", 32'(n_ld), 32'd1);
        check("negzero_shift", 32'(n_shift), 32'd16);
        check("negzero_sub", 32'(n_sub), 32'd16);
        check("negzero_setq", 32'(n_setq), 32'd16);
        check("negzero_rest", 32'(n_rest), 32'd0);
        accept("negzero_acc");

        // Alternating Neg.
        neg_mode = 1;
        restart_count();
        start_op(1'b0);
        wait_done(n);
        check("alt_latency", 32'(n), 32'(OpCycles));
        check("alt_count15", 32'(bus.Count), 32'd15);
        check("alt_rest_mask", 32'(rest_mask), 32'h5555);
        check("alt_setq_mask", 32'(setq_mask), 32'hAAAA);
        accept("alt_acc");
        neg_mode = 0;

        // Divide by zero, then a clean operation clears Error.
        restart_count();
        start_op(1'b1);
        wait_done(n);
        bus.DivisorZero = 1'b0;
        check("dz_latency", 32'(n), 32'd1);
        check("dz_error", 32'(bus.Error), 32'd1);
        check("dz_no_shift", 32'(n_shift), 32'd0);
        check("dz_no_sub", 32'(n_sub), 32'd0);
        check("dz_ld", 32'(n_ld), 32'd1);
        accept("dz_acc");
        start_op(1'b0);
        wait_done(n);
        check("dz_next_error", 32'(bus.Error), 32'd0);
        accept("dz_next_acc");

        // Reset in the middle of an operation.
        start_op(1'b0);
        guard = 0;
        while (bus.Count != 5 && guard < 100) begin step(); guard++; end
        check("midrst_reach5", 32'(bus.Count), 32'd5);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_idle("midrst");
        start_op(1'b0);
        wait_done(n);
        check("midrst_latency", 32'(n), 32'(OpCycles));
        accept("midrst_acc");

        // Start ignored mid-op and in DONE; acceptance delayed.
        restart_count();
        start_op(1'b0);
        guard = 0;
        while (bus.Count != 3 && guard < 100) begin step(); guard++; end
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_done(n);
        check("ign_ld_once", 32'(n_ld), 32'd1);
        bus.Start = 1'b1;
        guard = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.Done && !bus.ReadyForInput) guard++;
        end
        check("ign_done_held", 32'(guard), 32'd10);
        bus.OutputAccepted = 1'b1;
        step();
        bus.OutputAccepted = 1'b0;
        bus.Start = 1'b0;
        check("ign_ready_after_acc", 32'(bus.ReadyForInput), 32'd1);
        restart_count();
        step();
        step();
        check("ign_no_relaunch", 32'(n_ld), 32'd0);
        check("ign_still_idle", 32'(bus.ReadyForInput), 32'd1);

`ifdef DIV_STATUS_EN
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("st_opcount_rst", 32'(bus.OpCount), 32'd0);
        check("st_busy_rst", 32'(bus.Busy), 32'd0);
        restart_count();
        for (int k = 0; k < 3; k++) begin
            start_op(1'b0);
            wait_done(n);
            accept("st_acc");
        end
        check("st_opcount3", 32'(bus.OpCount), 32'd3);
        check("st_busy_cycles", 32'(n_busy), 32'(3 * OpCycles));
        start_op(1'b1);
        wait_done(n);
        accept("st_err_acc");
        check("st_opcount_err", 32'(bus.OpCount), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
